// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: two-approach traffic-light phase scheduler with demand-timed greens and saturating queue counts.
// Define TLC_PED_EN to build the pedestrian walk phase (ped_req/walk ports, extended all-red clearance).
module tlc_phase_scheduler #(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 12,
    parameter int YEL_TICKS  = 3,
    parameter int RED_TICKS  = 1,
    parameter int WALK_TICKS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       car_ew,
`ifdef TLC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] ns_count,
    output logic [3:0] ew_count,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } state_t;

    localparam logic [4:0] MIN_T   = 5'(MIN_GREEN);
    localparam logic [4:0] MAX_T   = 5'(MAX_GREEN);
    localparam logic [4:0] YEL_T   = 5'(YEL_TICKS);
    localparam logic [4:0] RED_T   = 5'(RED_TICKS);
    localparam logic [3:0] TMR_SAT = 4'(MAX_GREEN);

    state_t     state;
    state_t     state_next;
    logic [3:0] timer;
    logic [4:0] t;
    logic [4:0] red_t;
    logic       changing;
    logic       ns_yield;
    logic       ew_yield;
    logic       ns_dep;
    logic       ew_dep;

    function automatic logic [3:0] queue_next(input logic [3:0] q, input logic arrive, input logic depart);
        return (arrive && !depart && q != 4'd15) ? q + 4'd1 :
               (depart && !arrive && q != 4'd0)  ? q - 4'd1 : q;
    endfunction

    assign t        = {1'b0, timer} + 5'd1;
    assign changing = state_next != state;
    assign ns_dep   = tick && state == NS_GREEN;
    assign ew_dep   = tick && state == EW_GREEN;
    assign ns_yield = t >= MIN_T && ew_count != 4'd0 && (ns_count == 4'd0 || t >= MAX_T);
    assign ew_yield = t >= MIN_T && ns_count != 4'd0 && (ew_count == 4'd0 || t >= MAX_T);

`ifdef TLC_PED_EN
    localparam logic [4:0] WALK_T = 5'(WALK_TICKS);
    logic pending;
    logic walk_q;
    logic entering_red;
    assign entering_red = changing && (state_next == ALL_RED_A || state_next == ALL_RED_B);
    assign red_t        = walk_q ? WALK_T : RED_T;
    assign walk         = walk_q;
    // Hold button presses until an all-red entry consumes them and lights walk for that clearance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            pending <= (entering_red && pending) ? ped_req : (pending | ped_req);
            walk_q  <= entering_red ? pending : (changing ? 1'b0 : walk_q);
        end
    end
`else
    assign red_t = RED_T;
`endif

    // State register, phase timer and queue counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ALL_RED_B;
            timer    <= 4'd0;
            ns_count <= 4'd0;
            ew_count <= 4'd0;
        end else begin
            state    <= state_next;
            timer    <= changing ? 4'd0 : (tick && timer != TMR_SAT) ? timer + 4'd1 : timer;
            ns_count <= queue_next(ns_count, car_ns, ns_dep);
            ew_count <= queue_next(ew_count, car_ew, ew_dep);
        end
    end

    // Next phase: greens yield on demand, yellow and all-red run fixed tick counts
    always_comb begin
        state_next = state;
        case (state)
            NS_GREEN:  state_next = (tick && ns_yield)  ? NS_YELLOW : state;
            NS_YELLOW: state_next = (tick && t == YEL_T) ? ALL_RED_A : state;
            ALL_RED_A: state_next = (tick && t == red_t) ? EW_GREEN  : state;
            EW_GREEN:  state_next = (tick && ew_yield)  ? EW_YELLOW : state;
            EW_YELLOW: state_next = (tick && t == YEL_T) ? ALL_RED_B : state;
            ALL_RED_B: state_next = (tick && t == red_t) ? NS_GREEN  : state;
            default:   state_next = ALL_RED_B;
        endcase
    end

    // Lamp and phase outputs decoded from the state register only
    always_comb begin
        phase    = state;
        ns_light = state == NS_GREEN ? 3'b001 : state == NS_YELLOW ? 3'b010 : 3'b100;
        ew_light = state == EW_GREEN ? 3'b001 : state == EW_YELLOW ? 3'b010 : 3'b100;
    end
endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Two-approach traffic-light phase scheduler for the intersection controller. Keeps a 4-bit saturating car queue count per approach (NS, EW) and sequences green/yellow/all-red phases on a slow tick. Green time depends on queue demand with min/max bounds. Sits between the car-sensor/tick generation logic and the lamp drivers and seven-segment count displays.

## Interface
- MIN_GREEN, 4: ticks a green must last before it may yield.
- MAX_GREEN, 12: ticks after which a green yields if the other queue is non-zero.
- YEL_TICKS, 3: yellow duration in ticks.
- RED_TICKS, 1: all-red clearance duration in ticks.
- WALK_TICKS, 6: all-red duration when a walk phase is serviced (TLC_PED_EN only).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle timing strobe; all phase timing counts tick cycles.
- car_ns  in  1  one-cycle NS arrival pulse.
- car_ew  in  1  one-cycle EW arrival pulse.
- ped_req  in  1  pedestrian button pulse (TLC_PED_EN only).
- ns_light  out  3  {red, yellow, green}, one-hot.
- ew_light  out  3  {red, yellow, green}, one-hot.
- ns_count  out  4  NS queue count.
- ew_count  out  4  EW queue count.
- phase  out  3  state code.
- walk  out  1  walk lamp (TLC_PED_EN only).

## Operation
- States and phase codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5. Codes 6–7 are illegal and go to ALL_RED_B on the next clock.
- Cycle order: NS_GREEN → NS_YELLOW → ALL_RED_A → EW_GREEN → EW_YELLOW → ALL_RED_B → NS_GREEN.
- Phase timer: 4-bit, counts ticks in the current state, clears to 0 on every state change, saturates at MAX_GREEN.
- Let t = timer+1 on a tick cycle. All conditions use pre-edge register values.
- Green exit, evaluated only on tick cycles: exit when t ≥ MIN_GREEN AND other count ≠ 0 AND (own count = 0 OR t ≥ MAX_GREEN).
  - If the other count = 0, green holds indefinitely.
- Yellow exit: on a tick with t = YEL_TICKS.
- All-red exit: on a tick with t = RED_TICKS.
- Queue counters:
  - Arrival pulse: +1, saturating at 15.
  - Departure: −1, saturating at 0. A departure is a tick cycle while that approach is green, including the tick that causes green exit.
  - Arrival and departure in the same cycle on one counter: count unchanged, at any value, including 0 and 15.
- Lights are Moore outputs decoded from the state register.
  - The green approach shows 100→001 (green); during its yellow it shows 010; all other approaches show 100.
  - Both approaches show 100 in ALL_RED_A/B.

## Timing
- Reset values: phase=5 (ALL_RED_B), timer=0, ns_count=0, ew_count=0, ns_light=ew_light=3'b100, walk=0, ped pending=0.
- Reset acts immediately and asynchronously, including mid-phase. Release is sampled at the next rising edge.
- State, count and light changes are visible the cycle after the qualifying tick or pulse edge.
- There is no combinational path from inputs to outputs.
- The first NS_GREEN is reached on the edge of the first tick after reset release (RED_TICKS=1).
- tick asserted for consecutive cycles counts as consecutive ticks.

## Configuration
- TLC_PED_EN defined:
  - ped_req and walk ports exist.
  - ped_req sets a pending flag; repeated presses are absorbed.
  - On entry to ALL_RED_A or ALL_RED_B with the flag set: walk=1, the flag clears, and that all-red lasts WALK_TICKS instead of RED_TICKS.
  - walk drops on exiting that all-red.
  - A ped_req during an active walk re-arms the flag for the next all-red.
- TLC_PED_EN undefined: ports absent, all-red always lasts RED_TICKS, behaviour otherwise identical.

## Test plan
- Reset, then one tick: all outputs at reset values, then phase=0 and ns_light=001. With no cars, 20 further ticks leave phase=0.
- Enter NS_GREEN, then three car_ew pulses (ns_count=0): exits on the 4th tick in green.
  - Then phase 1 for 3 ticks, phase 2 for 1 tick, then phase 3.
  - 3 more ticks reach ew_count=0 and phase stays 3.
- 17 car_ns pulses give ns_count=15. Then one car_ew while NS_GREEN: yields on the 12th tick (MAX_GREEN) with ns_count=3.
- ns_count=5 in NS_GREEN, car_ns coincident with tick: ns_count stays 5. car_ew at ew_count=15 stays 15. A tick in green at count 0 stays 0.
- rst_n low for 1 cycle mid EW_YELLOW (ew_count=7): outputs immediately read phase=5, both lights 100, counts 0.
- TLC_PED_EN defined, ped_req during NS_GREEN: walk=1 for exactly 6 ticks in ALL_RED_A, then EW_GREEN. The following ALL_RED_B lasts 1 tick with walk=0.
